// File: rtl/uart_boot_loader.sv
// UART program loader: receives an 8N1 image (count, words, checksum) and feeds
// it into the CPU boot interface, holding the CPU in debug mode until verified.
module uart_boot_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 8192
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        debug,
    output logic [31:0] boot_addr,
    output logic [31:0] boot_data,
    output logic        boot_done,
    output logic        boot_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_DATA = 2'd2, R_STOP = 2'd3;
    localparam logic [2:0] S_LEN = 3'd0, S_DATA = 3'd1, S_CHK = 3'd2, S_DONE = 3'd3, S_ERR = 3'd4;

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]    rx_st_q, rx_st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          byte_vld, frame_err;

    logic [2:0]    st_q, st_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [31:0]   len_q, len_d, word_q, word_d, idx_q, idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [31:0]   addr_q, addr_d, data_q, data_d;
    logic [31:0]   new_len, new_word;

    // Bit engine: start bit re-checked at mid-bit, all later samples one bit apart
    always_comb begin
        rx_st_d   = rx_st_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        byte_vld  = 1'b0;
        frame_err = 1'b0;
        case (rx_st_q)
            R_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_st_d = R_START;
                cnt_d   = '0;
            end
            R_START: if (cnt_q == HALF_LAST) begin
                cnt_d   = '0;
                bit_d   = 3'd0;
                rx_st_d = rx_s2_q ? R_IDLE : R_DATA;
            end else cnt_d = cnt_q + CW'(1);
            R_DATA: if (cnt_q == BIT_LAST) begin
                cnt_d = '0;
                sh_d  = {rx_s2_q, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) rx_st_d = R_STOP;
            end else cnt_d = cnt_q + CW'(1);
            default: if (cnt_q == BIT_LAST) begin
                rx_st_d   = R_IDLE;
                byte_vld  = rx_s2_q;
                frame_err = !rx_s2_q;
            end else cnt_d = cnt_q + CW'(1);
        endcase
    end

    assign new_len  = {sh_q, len_q[31:8]};
    assign new_word = {sh_q, word_q[31:8]};

    always_comb begin
        st_d   = st_q;
        bcnt_d = bcnt_q;
        len_d  = len_q;
        word_d = word_q;
        idx_d  = idx_q;
        csum_d = csum_q;
        addr_d = addr_q;
        data_d = data_q;
        case (st_q)
            S_LEN: if (byte_vld) begin
                len_d  = new_len;
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    if (new_len > 32'(MAX_WORDS)) st_d = S_ERR;
                    else if (new_len == 32'd0)    st_d = S_CHK;
                    else                          st_d = S_DATA;
                end
            end
            S_DATA: if (byte_vld) begin
                word_d = new_word;
                csum_d = csum_q + sh_q;
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    data_d = new_word;
                    addr_d = BASE_ADDR + {idx_q[29:0], 2'b00};
                    idx_d  = idx_q + 32'd1;
                    if (idx_d == len_q) st_d = S_CHK;
                end
            end
            S_CHK: if (byte_vld) st_d = (sh_q == csum_q) ? S_DONE : S_ERR;
            default: ;
        endcase
        // Once loaded or failed, line traffic (including bad frames) is ignored
        if (frame_err && (st_q == S_LEN || st_q == S_DATA || st_q == S_CHK)) st_d = S_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= R_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            sh_q      <= 8'd0;
            st_q      <= S_LEN;
            bcnt_q    <= 2'd0;
            len_q     <= 32'd0;
            word_q    <= 32'd0;
            idx_q     <= 32'd0;
            csum_q    <= 8'd0;
            addr_q    <= BASE_ADDR;
            data_q    <= 32'd0;
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_st_q   <= rx_st_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            st_q      <= st_d;
            bcnt_q    <= bcnt_d;
            len_q     <= len_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign debug     = (st_q != S_DONE);
    assign boot_done = (st_q == S_DONE);
    assign boot_err  = (st_q == S_ERR);
    assign boot_addr = addr_q;
    assign boot_data = data_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed plus randomized image loads against a byte-stream reference model.
module tb_uart_boot_loader;
    localparam int          CPB  = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        debug, boot_done, boot_err;
    logic [31:0] boot_addr, boot_data;

    int vectors = 0;
    int miscompares = 0;

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .debug(debug),
        .boot_addr(boot_addr), .boot_data(boot_data),
        .boot_done(boot_done), .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cyc(CPB);
        end
        uart_rx = stop;
        cyc(CPB);
        uart_rx = 1'b1;
    endtask

    task automatic do_reset;
        uart_rx = 1'b1;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
    endtask

    // Sends count n, n words and checksum (+delta); checks against the byte-level model
    task automatic load_image(input int n, input logic [31:0] words [0:7], input logic [7:0] delta);
        logic [31:0] nv, exp_addr, exp_data;
        logic [7:0]  sum, b;
        logic        ok;
        nv = 32'(n);
        exp_addr = BASE;
        exp_data = 32'd0;
        sum = 8'd0;
        for (int i = 0; i < 4; i++) send_byte(nv[8*i +: 8], 1'b1);
        if (n > MAXW) begin
            chk("len_err", {31'd0, boot_err}, 32'd1);
            chk("len_err_dbg", {31'd0, debug}, 32'd1);
            chk("len_err_data", boot_data, 32'd0);
            return;
        end
        chk("len_data", boot_data, 32'd0);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = words[w][8*k +: 8];
                sum = sum + b;
                send_byte(b, 1'b1);
                cyc($urandom_range(0, 2));
            end
            exp_addr = BASE + 32'(4 * w);
            exp_data = words[w];
            chk("word_addr", boot_addr, exp_addr);
            chk("word_data", boot_data, exp_data);
            chk("word_dbg", {31'd0, debug}, 32'd1);
        end
        send_byte(sum + delta, 1'b1);
        ok = (delta == 8'd0);
        chk("end_dbg", {31'd0, debug}, {31'd0, !ok});
        chk("end_done", {31'd0, boot_done}, {31'd0, ok});
        chk("end_err", {31'd0, boot_err}, {31'd0, !ok});
        chk("end_addr", boot_addr, exp_addr);
        chk("end_data", boot_data, exp_data);
    endtask

    initial begin
        logic [31:0] img [0:7];
        logic [7:0]  d;
        int          n;
        for (int i = 0; i < 8; i++) img[i] = 32'd0;
        #1;
        do_reset;
        chk("rst_dbg", {31'd0, debug}, 32'd1);
        chk("rst_addr", boot_addr, BASE);
        chk("rst_data", boot_data, 32'd0);
        chk("rst_done", {31'd0, boot_done}, 32'd0);
        chk("rst_err", {31'd0, boot_err}, 32'd0);

        // Short glitch must be discarded; the following image must still line up
        uart_rx = 1'b0;
        cyc(2);
        uart_rx = 1'b1;
        cyc(30);
        chk("glitch_err", {31'd0, boot_err}, 32'd0);
        img[0] = 32'h13;
        img[1] = 32'h73;
        load_image(2, img, 8'd0);
        send_byte(8'h55, 1'b1);
        chk("done_ignore", {31'd0, boot_done}, 32'd1);
        chk("done_ignore_data", boot_data, 32'h73);

        do_reset;
        load_image(2, img, 8'hFF);

        do_reset;
        load_image(0, img, 8'd0);

        do_reset;
        send_byte(8'h02, 1'b0);
        cyc(4);
        chk("frame_err", {31'd0, boot_err}, 32'd1);
        chk("frame_dbg", {31'd0, debug}, 32'd1);

        do_reset;
        load_image(5, img, 8'd0);

        // Reset after 6 bytes of a two-word image, then full retransmission
        do_reset;
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h02 : 8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dbg", {31'd0, debug}, 32'd1);
        chk("mid_rst_addr", boot_addr, BASE);
        chk("mid_rst_data", boot_data, 32'd0);
        chk("mid_rst_err", {31'd0, boot_err}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        load_image(2, img, 8'd0);

        for (int t = 0; t < 6; t++) begin
            do_reset;
            n = int'($urandom_range(0, MAXW));
            for (int i = 0; i < 8; i++) img[i] = $urandom;
            d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            load_image(n, img, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
